// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port synchronous RAM.
// Contents:
//   state_e   - init sequencer states (ST_INIT, ST_RUN)
//   RDW_OLD / RDW_NEW - read-during-write policy encodings
//   calc_nb() - number of byte-enable lanes for a given word/lane width
package ram_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic int calc_nb(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/dual_port_sync_ram_if.sv
// Bus interface of the dual-port synchronous RAM.
// Signals:
//   init_busy - RAM is filling itself after reset, accesses ignored
//   wr_en / wr_addr / wr_data / wr_be - write port with per-lane enables
//   rd_en / rd_addr - read request
//   rd_data / rd_valid - read result and its one-cycle completion strobe
// Modports: master (user side), slave (RAM side).
interface dual_port_sync_ram_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NB         = 1
);

    logic                  init_busy;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NB-1:0]         wr_be;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    modport master (
        input  init_busy, rd_data, rd_valid,
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr
    );

    modport slave (
        output init_busy, rd_data, rd_valid,
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr
    );

endinterface

// File: rtl/ram_init_ctrl.sv
// Init sequencer: after every reset it walks init_addr_o from 0 to DEPTH-1,
// one word per cycle, then parks in ST_RUN.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   init_busy_o  - high from reset until the edge that writes the last word
//   init_we_o    - write strobe for the init path (same timing as busy)
//   init_addr_o  - address currently being initialised
module ram_init_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_busy_o,
    output logic                  init_we_o,
    output logic [ADDR_WIDTH-1:0] init_addr_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + ADDR_WIDTH'(1);
                    // busy drops on the same edge that writes the last word
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_INIT;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign init_busy_o = busy_q;
    assign init_we_o   = busy_q;
    assign init_addr_o = cnt_q;

endmodule

// File: rtl/dual_port_sync_ram.sv
// Simple-dual-port synchronous RAM: one write port with byte enables, one
// read port, selectable read-during-write policy, optional output register
// and a hardware init sequencer that fills the array after every reset.
// Ports:
//   clk    - single rising-edge clock
//   rst_n  - asynchronous active-low reset (control and output registers;
//            the array itself is not reset)
//   bus    - dual_port_sync_ram_if.slave (write port, read port, init_busy)
module dual_port_sync_ram
    import ram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    BYTE_WIDTH = 8,
    parameter int                    OUT_REG    = 0,
    parameter int                    RDW_MODE   = RDW_OLD,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dual_port_sync_ram_if.slave  bus
);

    localparam int NB    = calc_nb(DATA_WIDTH, BYTE_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic                  init_busy;
    logic                  init_we;
    logic [ADDR_WIDTH-1:0] init_addr;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NB-1:0]         mem_be;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  wr_fire;
    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] rd_data_p1_q;
    logic                  rd_vld_p1_q;

    ram_init_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_busy_o (init_busy),
        .init_we_o   (init_we),
        .init_addr_o (init_addr)
    );

    assign bus.init_busy = init_busy;

    // User accesses are only honoured once the array has been filled.
    assign wr_fire = bus.wr_en && !init_busy;
    assign rd_fire = bus.rd_en && !init_busy;

    // Write mux: the init path owns the array while the sequencer runs.
    always_comb begin
        mem_we    = wr_fire;
        mem_addr  = bus.wr_addr;
        mem_wdata = bus.wr_data;
        mem_be    = bus.wr_be;
        if (init_we) begin
            mem_we    = 1'b1;
            mem_addr  = init_addr;
            mem_wdata = INIT_VAL;
            mem_be    = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) begin
                    mem_q[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                        mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Collision merge: in new-data mode a same-address read sees exactly the
    // word the concurrent write leaves behind (enabled lanes replaced).
    always_comb begin
        rd_word = mem_q[bus.rd_addr];
        if (RDW_MODE == RDW_NEW && wr_fire && bus.wr_addr == bus.rd_addr) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.wr_be[i]) begin
                    rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] =
                        bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // ---- stage p1: array read register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_p1_q <= '0;
            rd_vld_p1_q  <= 1'b0;
        end else begin
            rd_vld_p1_q <= rd_fire;
            if (rd_fire) begin
                rd_data_p1_q <= rd_word;
            end
        end
    end

    // ---- stage p2: optional output register ----
    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] rd_data_p2_q;
        logic                  rd_vld_p2_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_p2_q <= '0;
                rd_vld_p2_q  <= 1'b0;
            end else begin
                rd_vld_p2_q <= rd_vld_p1_q;
                if (rd_vld_p1_q) begin
                    rd_data_p2_q <= rd_data_p1_q;
                end
            end
        end

        assign bus.rd_data  = rd_data_p2_q;
        assign bus.rd_valid = rd_vld_p2_q;
    end else begin : g_no_out_reg
        assign bus.rd_data  = rd_data_p1_q;
        assign bus.rd_valid = rd_vld_p1_q;
    end

endmodule

// File: tb/tb_dual_port_sync_ram.sv
// Directed bench for dual_port_sync_ram. Two instances share one stimulus:
//   dutA: OUT_REG=0, RDW_MODE=0 (old data), INIT_VAL=16'h0000
//   dutB: OUT_REG=1, RDW_MODE=1 (new data), INIT_VAL=16'hC3A5
module tb_dual_port_sync_ram;

    localparam logic [15:0] INIT_A = 16'h0000;
    localparam logic [15:0] INIT_B = 16'hC3A5;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        rd_en;
    logic [3:0]  rd_addr;

    int n_checks;
    int n_pass;

    dual_port_sync_ram_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .NB(2)) ifA ();
    dual_port_sync_ram_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .NB(2)) ifB ();

    assign ifA.wr_en   = wr_en;
    assign ifA.wr_addr = wr_addr;
    assign ifA.wr_data = wr_data;
    assign ifA.wr_be   = wr_be;
    assign ifA.rd_en   = rd_en;
    assign ifA.rd_addr = rd_addr;
    assign ifB.wr_en   = wr_en;
    assign ifB.wr_addr = wr_addr;
    assign ifB.wr_data = wr_data;
    assign ifB.wr_be   = wr_be;
    assign ifB.rd_en   = rd_en;
    assign ifB.rd_addr = rd_addr;

    dual_port_sync_ram #(
        .DATA_WIDTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
        .OUT_REG(0), .RDW_MODE(0), .INIT_VAL(INIT_A)
    ) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifA)
    );

    dual_port_sync_ram #(
        .DATA_WIDTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
        .OUT_REG(1), .RDW_MODE(1), .INIT_VAL(INIT_B)
    ) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [1:0]  be;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_be   = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busyA"}, 32'(ifA.init_busy), 32'h1);
        check({tag, "_busyB"}, 32'(ifB.init_busy), 32'h1);
        check({tag, "_vldA"},  32'(ifA.rd_valid),  32'h0);
        check({tag, "_vldB"},  32'(ifB.rd_valid),  32'h0);
        check({tag, "_dataA"}, 32'(ifA.rd_data),   32'h0);
        check({tag, "_dataB"}, 32'(ifB.rd_data),   32'h0);
    endtask

    // Counts edges from reset release until init_busy falls, while trying a
    // write and a read that must both be ignored.
    task automatic wait_init(input string tag);
        int cycles;
        bit seen_vld;
        cycles   = 0;
        seen_vld = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hFFFF; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 4'd2;
        while (cycles < 40) begin
            tick();
            cycles++;
            if (ifA.rd_valid || ifB.rd_valid) seen_vld = 1'b1;
            if (!ifA.init_busy) break;
        end
        idle_inputs();
        check({tag, "_busy_cycles"}, 32'(cycles), 32'd16);
        check({tag, "_busyB_low"}, 32'(ifB.init_busy), 32'h0);
        check({tag, "_no_vld_in_init"}, 32'(seen_vld), 32'h0);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input string name, input logic [3:0] a,
                           input logic [15:0] ea, input logic [15:0] eb);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        check({name, "_vldA"},  32'(ifA.rd_valid), 32'h1);
        check({name, "_dataA"}, 32'(ifA.rd_data),  32'(ea));
        check({name, "_vldB_early"}, 32'(ifB.rd_valid), 32'h0);
        tick();
        check({name, "_vldA_strobe"}, 32'(ifA.rd_valid), 32'h0);
        check({name, "_holdA"}, 32'(ifA.rd_data), 32'(ea));
        check({name, "_vldB"},  32'(ifB.rd_valid), 32'h1);
        check({name, "_dataB"}, 32'(ifB.rd_data),  32'(eb));
        tick();
        check({name, "_vldB_strobe"}, 32'(ifB.rd_valid), 32'h0);
    endtask

    initial begin
        logic [15:0] bd_a [5];
        logic [15:0] bd_b [5];
        logic        bv_a [5];
        logic        bv_b [5];

        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        idle_inputs();

        // Vector table: init contents, byte lanes, independent addresses.
        for (int i = 0; i < 16; i++)
            tbl.push_back('{1'b0, 4'(i), 16'h0, 2'b00, INIT_A, INIT_B});
        tbl.push_back('{1'b1, 4'd3, 16'h1234, 2'b11, 16'h0, 16'h0});
        tbl.push_back('{1'b0, 4'd3, 16'h0,    2'b00, 16'h1234, 16'h1234});
        tbl.push_back('{1'b1, 4'd3, 16'hAB00, 2'b10, 16'h0, 16'h0});
        tbl.push_back('{1'b0, 4'd3, 16'h0,    2'b00, 16'hAB34, 16'hAB34});
        tbl.push_back('{1'b1, 4'd3, 16'hFFFF, 2'b00, 16'h0, 16'h0});
        tbl.push_back('{1'b0, 4'd3, 16'h0,    2'b00, 16'hAB34, 16'hAB34});
        tbl.push_back('{1'b1, 4'd3, 16'h00CD, 2'b01, 16'h0, 16'h0});
        tbl.push_back('{1'b0, 4'd3, 16'h0,    2'b00, 16'hABCD, 16'hABCD});
        tbl.push_back('{1'b1, 4'd5, 16'h1111, 2'b11, 16'h0, 16'h0});
        tbl.push_back('{1'b1, 4'd7, 16'h5A5A, 2'b11, 16'h0, 16'h0});
        tbl.push_back('{1'b1, 4'd8, 16'hA5A5, 2'b11, 16'h0, 16'h0});
        tbl.push_back('{1'b0, 4'd7, 16'h0,    2'b00, 16'h5A5A, 16'h5A5A});
        tbl.push_back('{1'b0, 4'd8, 16'h0,    2'b00, 16'hA5A5, 16'hA5A5});
        tbl.push_back('{1'b0, 4'd5, 16'h0,    2'b00, 16'h1111, 16'h1111});

        // Reset state
        tick();
        tick();
        check_reset_vals("rst");

        // Init sequence with ignored accesses
        rst_n = 1'b1;
        wait_init("init1");

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].is_wr) do_write(tbl[i].addr, tbl[i].data, tbl[i].be);
            else do_read($sformatf("vec%0d", i), tbl[i].addr, tbl[i].exp_a, tbl[i].exp_b);
        end

        // Collision, full word: A returns old, B returns new
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h2222; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 4'd5;
        tick();
        idle_inputs();
        check("coll_vldA",  32'(ifA.rd_valid), 32'h1);
        check("coll_dataA", 32'(ifA.rd_data),  32'h1111);
        tick();
        check("coll_vldB",  32'(ifB.rd_valid), 32'h1);
        check("coll_dataB", 32'(ifB.rd_data),  32'h2222);
        tick();
        do_read("coll_after", 4'd5, 16'h2222, 16'h2222);

        // Collision, upper lane only: B sees merged word
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h3300; wr_be = 2'b10;
        rd_en = 1'b1; rd_addr = 4'd5;
        tick();
        idle_inputs();
        check("collp_dataA", 32'(ifA.rd_data), 32'h2222);
        tick();
        check("collp_dataB", 32'(ifB.rd_data), 32'h3322);
        tick();
        do_read("collp_after", 4'd5, 16'h3322, 16'h3322);

        // Back-to-back reads
        do_write(4'd3, 16'hAAAA, 2'b11);
        do_write(4'd4, 16'hBBBB, 2'b11);
        do_write(4'd5, 16'hCCCC, 2'b11);
        bd_a = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hCCCC, 16'hCCCC};
        bv_a = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bd_b = '{16'h0000, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hCCCC};
        bv_b = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 5; k++) begin
            rd_en   = (k < 3);
            rd_addr = 4'(3 + k);
            tick();
            check($sformatf("burst%0d_vldA", k), 32'(ifA.rd_valid), 32'(bv_a[k]));
            check($sformatf("burst%0d_dataA", k), 32'(ifA.rd_data), 32'(bd_a[k]));
            check($sformatf("burst%0d_vldB", k), 32'(ifB.rd_valid), 32'(bv_b[k]));
            if (k > 0)
                check($sformatf("burst%0d_dataB", k), 32'(ifB.rd_data), 32'(bd_b[k]));
        end
        idle_inputs();

        // Reset during init at init_cnt = 7
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        check("midinit_busy", 32'(ifA.init_busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midinit_rst");
        tick();
        rst_n = 1'b1;
        wait_init("init2");

        // Reset with a read in flight in the registered-output instance
        do_write(4'd9, 16'h9999, 2'b11);
        do_read("pre_rst", 4'd9, 16'h9999, 16'h9999);
        rd_en = 1'b1; rd_addr = 4'd9;
        tick();
        rd_en = 1'b0;
        check("inflight_vldA", 32'(ifA.rd_valid), 32'h1);
        check("inflight_vldB", 32'(ifB.rd_valid), 32'h0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("inflight_rst");
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("inflight_nostale%0d", k), 32'(ifB.rd_valid), 32'h0);
        end
        rst_n = 1'b1;
        wait_init("init3");
        do_read("post_rst", 4'd9, INIT_A, INIT_B);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dual_port_sync_ram.md
# dual_port_sync_ram

Parametrised simple-dual-port synchronous RAM with one write port and one read port. It is the next generation of the team's single-port synchronous RAM, adding:
- per-byte write enables,
- a selectable read-during-write policy,
- an optional output register,
- a hardware init sequencer that fills the array after every reset.

It serves as the generic storage primitive for buffers and lookup tables in the datapath.

## Interface
- DATA_WIDTH, 8: word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 4: address width; DEPTH = 2**ADDR_WIDTH words.
- BYTE_WIDTH, 8: bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH.
- OUT_REG, 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- RDW_MODE, 0: same-address read/write collision policy; 0 returns old data, 1 returns new (merged) data.
- INIT_VAL, 0: DATA_WIDTH-bit value written to every word by the init sequencer.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- init_busy  out  1  high while the init sequence runs; the RAM ignores accesses while high.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  NB  byte enables; bit i covers wr_data[i*BYTE_WIDTH +: BYTE_WIDTH].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data; holds its last value when no read completes.
- rd_valid  out  1  single-cycle strobe marking a completed read.

## Operation
- State machine has two states, ST_INIT and ST_RUN.
- While rst_n is low: state is ST_INIT, init counter is 0, init_busy=1, rd_valid=0, rd_data=0, and the output register (if present) is 0. The memory array itself has no reset.
- ST_INIT:
  - Each cycle writes INIT_VAL to address init_cnt, then increments init_cnt.
  - After writing address DEPTH-1, moves to ST_RUN. init_busy is high for exactly DEPTH cycles after rst_n rises.
  - wr_en and rd_en are ignored: no array update, rd_valid stays 0.
- ST_RUN:
  - A write with wr_en=1 updates only the lanes with wr_be[i]=1. wr_be=0 leaves the word unchanged.
  - A read with rd_en=1 samples rd_addr. The result appears on rd_data with a 1-cycle rd_valid strobe after the configured latency.
- Collision (rd_en and wr_en both high, rd_addr==wr_addr, same edge):
  - RDW_MODE=0: rd_data is the pre-write word.
  - RDW_MODE=1: rd_data takes wr_data lanes where wr_be=1 and old lanes otherwise, i.e. exactly the word stored after the write.
- Reads and writes to different addresses are independent. Every cycle supports one read plus one write.
- Reset asserted mid-operation (during init or run) immediately forces the reset values listed above. Any in-flight read is dropped with no rd_valid. On release, init restarts from address 0.

## Timing
- Read with OUT_REG=0: rd_en sampled at edge N, so rd_data and rd_valid are updated at edge N; rd_valid is high for the cycle N to N+1.
- Read with OUT_REG=1: the same results move one edge later, to N+1.
- Back-to-back reads sustain one result per cycle in both modes.
- Write: array is updated at the sampling edge. A read of the same address at a later edge sees the new data.
- First access accepted at the first edge where init_busy is low, which is edge DEPTH+1 after rst_n release.
- init_busy is registered and falls on the edge that writes address DEPTH-1.

## Structure
- Shared package ram_pkg holds:
  - the state typedef (ST_INIT, ST_RUN),
  - the helper function computing NB from DATA_WIDTH/BYTE_WIDTH,
  - RDW_OLD=0 and RDW_NEW=1 constants.
- Sub-module ram_init_ctrl contains the init FSM and the ADDR_WIDTH-bit counter. It outputs init_busy, init_we and init_addr.
- Top level contains the write mux (init path vs user path), the byte-lane array, collision merge, and the optional output stage.

## Test plan
All scenarios use DATA_WIDTH=16, ADDR_WIDTH=4, BYTE_WIDTH=8.
- Init: release rst_n with INIT_VAL=16'h0000 -> init_busy high for exactly 16 cycles; reads of addresses 0..15 all return 16'h0000 with a rd_valid strobe each.
- Byte enables: write 16'h1234 with be=2'b11 to addr 3, then 16'hAB00 with be=2'b10 to addr 3 -> read addr 3 returns 16'hAB34; a write with be=2'b00 leaves it unchanged.
- Collision: addr 5 holds 16'h1111; write 16'h2222 (be=2'b11) and read addr 5 at the same edge -> rd_data=16'h1111 with RDW_MODE=0, 16'h2222 with RDW_MODE=1; the next read returns 16'h2222 in both modes.
- Latency: with OUT_REG=1, preload addrs 3/4/5 with 16'hAAAA/16'hBBBB/16'hCCCC, then issue reads at edges N, N+1, N+2 -> data at edges N+1..N+3 in order, rd_valid high for 3 consecutive cycles. Repeat with OUT_REG=0 -> data one edge earlier.
- Access during init: wr_en to addr 2 with 16'hFFFF and rd_en during init -> no rd_valid; after init, addr 2 reads 16'h0000.
- Mid-op reset: assert rst_n low when init_cnt=7, and again with a read in flight under OUT_REG=1 -> rd_valid=0 and rd_data=0 asynchronously, no stale strobe; after release, init_busy is high for a full 16 cycles.
